// File: rtl/bcd_counter_4digit_pkg.sv
// Shared constants and helpers for the four-decade packed-BCD counter
// and the display scan stage that consumes its value.
package bcd_counter_4digit_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Packed-BCD digit slice offsets, digit0 in the least significant nibble
    localparam int unsigned DIGIT0_LSB = 0;
    localparam int unsigned DIGIT1_LSB = DIGIT0_LSB + DIGIT_W;
    localparam int unsigned DIGIT2_LSB = DIGIT1_LSB + DIGIT_W;
    localparam int unsigned DIGIT3_LSB = DIGIT2_LSB + DIGIT_W;

    typedef logic [BCD_W-1:0] bcd_word_t;

    function automatic int unsigned digit_lsb(input int unsigned idx);
        return idx * DIGIT_W;
    endfunction

    // True when every nibble of the word is a legal decimal digit
    function automatic logic bcd_valid(input bcd_word_t word);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (word[digit_lsb(i) +: DIGIT_W] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_counter_4digit_if.sv
// Control and result bundle between the counter and its controller.
interface bcd_counter_4digit_if;
    import bcd_counter_4digit_pkg::*;

    logic      EN;
    logic      UP;
    logic      CLR;
    logic      LOAD;
    bcd_word_t LOAD_VAL;
    bcd_word_t COUNT;
    logic      TICK;
    logic      CARRY;
    logic      ERR;

    modport master (
        output EN, UP, CLR, LOAD, LOAD_VAL,
        input  COUNT, TICK, CARRY, ERR
    );

    modport slave (
        input  EN, UP, CLR, LOAD, LOAD_VAL,
        output COUNT, TICK, CARRY, ERR
    );

endinterface

// File: rtl/bcd_counter_4digit_bcd_digit_cell.sv
// One combinational BCD decade: adds or subtracts the incoming carry/borrow
// and reports the carry/borrow out to the next decade.
module bcd_digit_cell
    import bcd_counter_4digit_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               ci,
    input  logic               up,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               co
);

    always_comb begin
        next_digit = digit;
        co         = 1'b0;
        if (ci) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    next_digit = '0;
                    co         = 1'b1;
                end else begin
                    next_digit = digit + DIGIT_W'(1);
                end
            end else begin
                if (digit == '0) begin
                    next_digit = BCD_MAX;
                    co         = 1'b1;
                end else begin
                    next_digit = digit - DIGIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4digit.sv
// Four-decade BCD up/down counter with tick prescaler, synchronous
// clear/load with invalid-load rejection, and wrap pulse.
module bcd_counter_4digit
    import bcd_counter_4digit_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PRE_W    = 26
) (
    input logic                 CLK,
    input logic                 RST,
    bcd_counter_4digit_if.slave bus
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q;
    bcd_word_t         count_q;
    logic              tick_q;
    logic              carry_q;
    logic              err_q;

    bcd_word_t         stepped_c;
    logic [NUM_DIGITS:0] ripple_c;
    logic              pre_last_c;
    logic              load_ok_c;

    // Ripple chain: digit0 always receives the step, higher decades follow
    assign ripple_c[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .digit      (count_q[digit_lsb(i) +: DIGIT_W]),
            .ci         (ripple_c[i]),
            .up         (bus.UP),
            .next_digit (stepped_c[digit_lsb(i) +: DIGIT_W]),
            .co         (ripple_c[i+1])
        );
    end

    assign pre_last_c = (pre_q == PRE_LAST);
    assign load_ok_c  = bcd_valid(bus.LOAD_VAL);

    // Control priority: clear, then load, then enabled prescale/step
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.CLR) begin
                pre_q   <= '0;
                count_q <= '0;
            end else if (bus.LOAD) begin
                if (load_ok_c) begin
                    pre_q   <= '0;
                    count_q <= bus.LOAD_VAL;
                end else begin
                    err_q   <= 1'b1;
                end
            end else if (bus.EN) begin
                if (pre_last_c) begin
                    pre_q   <= '0;
                    count_q <= stepped_c;
                    tick_q  <= 1'b1;
                    carry_q <= ripple_c[NUM_DIGITS];
                end else begin
                    pre_q   <= pre_q + PRE_W'(1);
                end
            end
        end
    end

    assign bus.COUNT = count_q;
    assign bus.TICK  = tick_q;
    assign bus.CARRY = carry_q;
    assign bus.ERR   = err_q;

endmodule

// File: tb/tb_bcd_counter_4digit.sv
// Directed bench for the four-decade BCD counter with TICK_DIV=4.
`timescale 1ns/1ps
module tb_bcd_counter_4digit;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned PRE_W    = 3;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    bcd_counter_4digit_if bus ();

    bcd_counter_4digit #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          cur      = 0;
    logic        dir_up   = 1'b1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] b1(input logic v);
        return {15'd0, v};
    endfunction

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    // Four enabled edges: three holds, then the step with its pulses
    task automatic step_once(input string tag);
        int  nxt;
        logic wrap;
        for (int unsigned i = 0; i < TICK_DIV - 1; i++) begin
            edge1();
            check({tag, "_hold_count"}, bus.COUNT, to_bcd(cur));
            check({tag, "_hold_tick"}, b1(bus.TICK), 16'd0);
            check({tag, "_hold_carry"}, b1(bus.CARRY), 16'd0);
        end
        if (dir_up) begin
            nxt  = (cur + 1) % 10000;
            wrap = (cur == 9999);
        end else begin
            nxt  = (cur + 9999) % 10000;
            wrap = (cur == 0);
        end
        edge1();
        cur = nxt;
        check({tag, "_count"}, bus.COUNT, to_bcd(cur));
        check({tag, "_tick"}, b1(bus.TICK), 16'd1);
        check({tag, "_carry"}, b1(bus.CARRY), b1(wrap));
    endtask

    task automatic do_load(input logic [15:0] val);
        bus.LOAD     = 1'b1;
        bus.LOAD_VAL = val;
        edge1();
        bus.LOAD     = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        bus.EN       = 1'b0;
        bus.UP       = 1'b1;
        bus.CLR      = 1'b0;
        bus.LOAD     = 1'b0;
        bus.LOAD_VAL = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_count", bus.COUNT, 16'h0000);
        check("rst_tick", b1(bus.TICK), 16'd0);
        check("rst_carry", b1(bus.CARRY), 16'd0);
        check("rst_err", b1(bus.ERR), 16'd0);

        // 1: count up from reset for 40 cycles
        bus.EN = 1'b1;
        bus.UP = 1'b1;
        dir_up = 1'b1;
        RST    = 1'b0;
        for (int k = 0; k < 10; k++) step_once("up_run");
        check("up_run_final", bus.COUNT, 16'h0010);
        edge1();
        check("up_run_tick_width", b1(bus.TICK), 16'd0);

        // 2: wrap up 9998 -> 9999 -> 0000
        do_load(16'h9998);
        cur = 9998;
        check("load9998_count", bus.COUNT, 16'h9998);
        check("load9998_tick", b1(bus.TICK), 16'd0);
        step_once("wrap_up");
        step_once("wrap_up");
        check("wrap_up_final", bus.COUNT, 16'h0000);
        edge1();
        check("wrap_up_carry_width", b1(bus.CARRY), 16'd0);

        // 3: count down through 0000 -> 9999 -> 9998
        do_load(16'h0001);
        cur    = 1;
        bus.UP = 1'b0;
        dir_up = 1'b0;
        check("load0001_count", bus.COUNT, 16'h0001);
        step_once("down");
        step_once("down_wrap");
        check("down_wrap_value", bus.COUNT, 16'h9999);
        step_once("down_after");
        check("down_after_value", bus.COUNT, 16'h9998);

        // 4: rejected load, then accepted load
        do_load(16'h12A4);
        check("bad_load_err", b1(bus.ERR), 16'd1);
        check("bad_load_count", bus.COUNT, 16'h9998);
        do_load(16'h1234);
        cur = 1234;
        check("good_load_err", b1(bus.ERR), 16'd0);
        check("good_load_count", bus.COUNT, 16'h1234);

        // 5: CLR with LOAD on a prescaler-terminal edge
        bus.UP = 1'b1;
        dir_up = 1'b1;
        repeat (TICK_DIV - 1) edge1();
        bus.CLR      = 1'b1;
        bus.LOAD     = 1'b1;
        bus.LOAD_VAL = 16'h0500;
        edge1();
        bus.CLR  = 1'b0;
        bus.LOAD = 1'b0;
        cur      = 0;
        check("clr_count", bus.COUNT, 16'h0000);
        check("clr_tick", b1(bus.TICK), 16'd0);
        check("clr_err", b1(bus.ERR), 16'd0);
        step_once("after_clr");

        // Rejected load on a terminal edge: step suppressed, prescaler held
        repeat (TICK_DIV - 1) edge1();
        do_load(16'hF000);
        check("term_bad_err", b1(bus.ERR), 16'd1);
        check("term_bad_tick", b1(bus.TICK), 16'd0);
        check("term_bad_count", bus.COUNT, 16'h0001);
        edge1();
        cur = 2;
        check("term_bad_resume_tick", b1(bus.TICK), 16'd1);
        check("term_bad_resume_count", bus.COUNT, 16'h0002);

        // 6: asynchronous reset at 0042, then EN=0 freeze
        do_load(16'h0041);
        cur = 41;
        step_once("to42");
        #3;
        RST = 1'b1;
        #1;
        check("async_rst_count", bus.COUNT, 16'h0000);
        check("async_rst_tick", b1(bus.TICK), 16'd0);
        check("async_rst_carry", b1(bus.CARRY), 16'd0);
        check("async_rst_err", b1(bus.ERR), 16'd0);
        cur = 0;
        edge1();
        #2;
        RST = 1'b0;
        repeat (2) edge1();
        bus.EN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge1();
            check("freeze_count", bus.COUNT, 16'h0000);
            check("freeze_tick", b1(bus.TICK), 16'd0);
        end
        bus.EN = 1'b1;
        edge1();
        check("unfreeze_pre3_tick", b1(bus.TICK), 16'd0);
        edge1();
        check("unfreeze_step_tick", b1(bus.TICK), 16'd1);
        check("unfreeze_step_count", bus.COUNT, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_4digit.md
Name: bcd_counter_4digit

Overview:
Four-decade BCD up/down counter with a built-in tick prescaler. It sits directly upstream of the display scan/decoder stage and supplies the 16-bit packed BCD value that stage multiplexes onto the seven-segment digits. It supports synchronous load, clear, enable and direction control, a wrap/borrow pulse, and rejection of invalid loads.

Parameters:
TICK_DIV, 50_000_000, CLK cycles per count step; legal range >= 1; TICK_DIV=1 means one step per enabled cycle.
PRE_W, 26, prescaler register width; must satisfy 2**PRE_W >= TICK_DIV.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  count enable; gates both the prescaler and stepping.
UP  input  1  direction: 1 = increment, 0 = decrement; sampled on the step edge.
CLR  input  1  synchronous clear to 0000.
LOAD  input  1  synchronous load of LOAD_VAL.
LOAD_VAL  input  16  packed BCD, digit3 in [15:12] down to digit0 in [3:0].
COUNT  output  16  packed BCD count, same digit order as LOAD_VAL.
TICK  output  1  registered one-cycle pulse, high in the cycle after each count step.
CARRY  output  1  registered one-cycle pulse on wrap: 9999->0000 when counting up, 0000->9999 when counting down.
ERR  output  1  registered one-cycle pulse when a LOAD is rejected.

Behaviour:
- One clock domain: CLK. Reset: RST is asynchronous and active-high.
- Reset values: COUNT=16'h0000, TICK=0, CARRY=0, ERR=0, prescaler PRE=0.
- Per-edge priority: RST > CLR > LOAD > step.
- CLR: COUNT<=0000, PRE<=0. TICK, CARRY and ERR are 0 next cycle. LOAD is ignored in the same cycle.
- LOAD with every nibble <= 9: COUNT<=LOAD_VAL, PRE<=0, TICK=0, CARRY=0.
- LOAD with any nibble > 9: COUNT and PRE hold, ERR=1 for exactly one cycle.
- A LOAD (accepted or rejected) on a prescaler-terminal cycle suppresses that step entirely: no TICK, no CARRY.
- Prescaler, when EN=1 and no CLR/LOAD:
  - If PRE != TICK_DIV-1: PRE<=PRE+1.
  - If PRE == TICK_DIV-1 (the step edge): PRE<=0, COUNT<=stepped value, TICK<=1, CARRY<=wrap flag.
- EN=0: PRE and COUNT hold. TICK and CARRY are 0.
- Step rules, with a ripple between decades inside the single cycle:
  - Up: digit0 +1; a digit at 9 goes to 0 and carries into the next digit.
  - Down: digit0 -1; a digit at 0 goes to 9 and borrows from the next digit.
  - The wrap flag is the carry or borrow out of digit3.
- Latency: the new COUNT and the TICK/CARRY pulses become visible together, in the cycle after the step edge.
- UP may change between steps freely; only its value at the step edge matters.
- Invariant: COUNT nibbles are always in 0..9, in every state reachable from reset.
- RST asserted mid-count: all outputs go to their reset values immediately, without waiting for a CLK edge. Counting resumes with PRE=0 on the first edge after RST deasserts.

Decomposition:
- Shared package/header holds:
  - BCD_MAX = 4'd9 and DIGIT_W = 4.
  - NUM_DIGITS = 4.
  - The packed-BCD digit slice offsets, also used by the downstream display scan stage.
- Natural sub-module: bcd_digit_cell, one combinational decade.
  - Inputs: digit[3:0], ci, up.
  - Outputs: next_digit[3:0], co.
  - Instantiated 4 times in a ripple chain; the top level holds the prescaler, the COUNT register and the control priority.

Test Plan (TICK_DIV=4 in the bench):
1. Reset, then EN=1 UP=1 for 40 cycles -> COUNT steps 0000,0001,...,0010. TICK pulses every 4th cycle, one cycle wide. CARRY stays 0.
2. LOAD LOAD_VAL=16'h9998, EN=1 UP=1 -> after 2 steps COUNT=0000. CARRY=1 coincident with the 9999->0000 update, for one cycle only.
3. LOAD 16'h0001, EN=1 UP=0 -> steps to 0000, then 9999 with CARRY=1. Next step 9998 with CARRY=0.
4. LOAD LOAD_VAL=16'h12A4 -> ERR=1 for one cycle, COUNT unchanged. A following LOAD 16'h1234 gives COUNT=1234, ERR=0.
5. Assert LOAD(16'h0500) and CLR together on a prescaler-terminal edge -> COUNT=0000, no TICK, PRE restarts (next TICK 4 enabled cycles later).
6. Assert RST asynchronously between CLK edges at COUNT=0042 -> COUNT=0000 and TICK/CARRY/ERR=0 before the next edge. EN=0 for 10 cycles -> COUNT and PRE frozen.
